// File: rtl/mem_arbiter_pkg.sv
// Package Common: types shared by the memory arbiter and its neighbours.
//   mem_inst_type_t : memory operation encoding; MEM_NOP means no access
//   arb_state_t     : arbiter FSM states (IDLE, BUSY, RESP)
//   arb_owner_t     : which requester owns the current transaction
//   is_store()      : true for the store operations (they return rdata 0)
package Common;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_inst_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  function automatic logic is_store(input mem_inst_type_t t);
    return (t == MEM_SB) || (t == MEM_SH) || (t == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch, data) arbiter in front of a
// single-ported memory. One transaction at a time: IDLE grants, BUSY waits
// for mem_ready_i (bounded by TIMEOUT cycles), RESP returns the read data.
//
// Parameters:
//   TIMEOUT      max BUSY cycles waiting for mem_ready_i (2..255)
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   if_*         fetch requester: req/addr in, gnt/rvalid/rdata out
//   d_*          data requester: req/type/addr/wdata in, gnt/rvalid/rdata out
//   mem_*        memory side: type/addr/wdata out, ready/rdata in
//   err_o        one-cycle pulse in RESP when the access timed out
// Build option:
//   MEM_ARB_RR_EN  defined: round-robin between simultaneous requests;
//                  undefined: data requester always wins.
module mem_arbiter
  import Common::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req_i,
  input  logic [31:0]    if_addr_i,
  output logic           if_gnt_o,
  output logic           if_rvalid_o,
  output logic [31:0]    if_rdata_o,
  input  logic           d_req_i,
  input  mem_inst_type_t d_type_i,
  input  logic [31:0]    d_addr_i,
  input  logic [31:0]    d_wdata_i,
  output logic           d_gnt_o,
  output logic           d_rvalid_o,
  output logic [31:0]    d_rdata_o,
  output mem_inst_type_t mem_type_o,
  output logic [31:0]    mem_addr_o,
  output logic [31:0]    mem_wdata_o,
  input  logic           mem_ready_i,
  input  logic [31:0]    mem_rdata_i,
  output logic           err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t     state_q, state_d;
  arb_owner_t     owner_q, owner_d;
  arb_owner_t     winner;
  logic           grant_any;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_inst_type_t type_q, type_d;
  mem_inst_type_t mem_type_q, mem_type_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    if_rdata_q, if_rdata_d;
  logic [31:0]    d_rdata_q, d_rdata_d;
  logic [31:0]    resp_data;
  logic           if_rvalid_q, if_rvalid_d;
  logic           d_rvalid_q, d_rvalid_d;
  logic           err_q, err_d;
`ifdef MEM_ARB_RR_EN
  arb_owner_t     last_win_q, last_win_d;
`endif

  // Winner select. Grants are only offered from IDLE and are suppressed
  // while reset is asserted so no requester sees a grant that is dropped.
  always_comb begin
    winner    = OWN_IF;
    grant_any = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      grant_any = if_req_i | d_req_i;
      if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
        winner = (last_win_q == OWN_IF) ? OWN_D : OWN_IF;
`else
        winner = OWN_D;
`endif
      end else if (d_req_i) begin
        winner = OWN_D;
      end
    end
  end

  assign if_gnt_o = grant_any && (winner == OWN_IF);
  assign d_gnt_o  = grant_any && (winner == OWN_D);

  // Next-state and output computation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_type_d  = MEM_NOP;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    err_d       = 1'b0;
    resp_data   = '0;
`ifdef MEM_ARB_RR_EN
    last_win_d  = last_win_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          owner_d = winner;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef MEM_ARB_RR_EN
          last_win_d = winner;
`endif
          if (winner == OWN_D) begin
            type_d  = d_type_i;
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
          end else begin
            // Fetches are always plain word loads with no write data.
            type_d  = MEM_LW;
            addr_d  = if_addr_i;
            wdata_d = '0;
          end
          mem_type_d = type_d;
        end
      end

      BUSY: begin
        mem_type_d = type_q;
        // Ready is tested first so a ready on the last allowed cycle wins
        // over the timeout.
        if (mem_ready_i || (cnt_q == CNT_LAST)) begin
          state_d    = RESP;
          mem_type_d = MEM_NOP;
          err_d      = !mem_ready_i;
          if (mem_ready_i && !is_store(type_q)) begin
            resp_data = mem_rdata_i;
          end
          if (owner_q == OWN_IF) begin
            if_rdata_d  = resp_data;
            if_rvalid_d = 1'b1;
          end else begin
            d_rdata_d  = resp_data;
            d_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      type_q      <= MEM_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_type_q  <= MEM_NOP;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_win_q  <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_type_q  <= mem_type_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      err_q       <= err_d;
`ifdef MEM_ARB_RR_EN
      last_win_q  <= last_win_d;
`endif
    end
  end

  assign mem_type_o  = mem_type_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
  assign err_o       = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum BUSY cycles spent waiting for mem_ready_i; legal range 2..255.
REQ-002 SHALL have ports clk (input, 1, the single clock) and rst (input, 1, synchronous active-high reset).
REQ-003 SHALL have instruction-fetch requester ports: if_req_i in 1, if_addr_i in 32, if_gnt_o out 1, if_rvalid_o out 1, if_rdata_o out 32.
REQ-004 SHALL have data requester ports: d_req_i in 1, d_type_i in mem_inst_type_t, d_addr_i in 32, d_wdata_i in 32, d_gnt_o out 1, d_rvalid_o out 1, d_rdata_o out 32.
REQ-005 SHALL have memory-side ports: mem_type_o out mem_inst_type_t, mem_addr_o out 32, mem_wdata_o out 32, mem_ready_i in 1, mem_rdata_i in 32, err_o out 1.

Function
REQ-006 SHALL implement a state machine with states IDLE, BUSY and RESP.
REQ-007 In IDLE with at least one request, SHALL pick one winner, pulse its gnt for that cycle, latch type/addr/wdata (instruction fetch type = MEM_NOP-free word load), record the owner, and go to BUSY.
REQ-008 gnt_o SHALL be combinational in IDLE only; a requester SHALL hold req and payload stable until it sees gnt.
REQ-009 In BUSY, SHALL drive mem_type_o/mem_addr_o/mem_wdata_o from the latched registers; in IDLE and RESP, mem_type_o SHALL be MEM_NOP.
REQ-010 In BUSY, on mem_ready_i=1, SHALL register mem_rdata_i and go to RESP.
REQ-011 In BUSY, SHALL keep a wait counter of width $clog2(TIMEOUT+1); the counter SHALL clear on entry to BUSY and increment each cycle without ready.
REQ-012 If the wait counter reaches TIMEOUT-1 without ready, SHALL go to RESP with rdata forced to 0 and err_o pulsed for the RESP cycle.
REQ-013 If mem_ready_i arrives on the same cycle the counter reaches TIMEOUT-1, ready SHALL win and err_o SHALL not assert.
REQ-014 In RESP, SHALL pulse the owner's rvalid for exactly one cycle with registered rdata; the non-owner rvalid SHALL stay 0; stores SHALL return rdata 0.
REQ-015 From RESP, SHALL return to IDLE; a new grant SHALL be possible in the following cycle, giving at most one transaction per 3 cycles.
REQ-016 Minimum latency SHALL be: gnt in cycle 0, ready in cycle 1, rvalid in cycle 2.
REQ-017 Outside RESP, rdata outputs SHALL hold their last value; gnt and rvalid SHALL never be high together for one requester.

Reset
REQ-018 On rst, SHALL go to IDLE with counter 0, owner = instruction fetch, latched registers 0, mem_type_o = MEM_NOP, and all gnt, rvalid and err_o at 0.
REQ-019 A reset in BUSY or RESP SHALL abandon the transaction with no rvalid and no err_o.

Configuration
REQ-020 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester that did not win last time wins, and the last winner resets to instruction fetch.
REQ-021 Without MEM_ARB_RR_EN, fixed priority SHALL apply and the data requester SHALL always win simultaneous requests.

Structure
REQ-022 The arb_state_t enum and arb_owner_t (OWN_IF, OWN_D) SHALL live in package Common, next to the existing mem_inst_type_t and MEM_NOP.
REQ-023 The block SHALL be a single module with no sub-modules; the winner-select logic SHALL be one always_comb block.

Verification
REQ-024 Single if_req_i with addr 0x8000_0000 and ready one cycle after gnt -> mem_addr_o = 0x8000_0000 in BUSY; if_rvalid_o in cycle 2 with if_rdata_o = mem_rdata_i (0x0000_0013).
REQ-025 Simultaneous if_req_i and d_req_i (word store to 0x100, data 0xDEAD_BEEF) -> fixed priority grants data first with mem_wdata_o = 0xDEAD_BEEF; the fetch is granted in the IDLE cycle after RESP.
REQ-026 With MEM_ARB_RR_EN defined, both requests held for 4 transactions -> grants alternate D, IF, D, IF.
REQ-027 mem_ready_i never asserted with TIMEOUT = 16 -> RESP after 16 BUSY cycles with err_o = 1 and d_rdata_o = 0; ready on cycle 16 -> no err_o.
REQ-028 rst asserted in the second BUSY cycle -> next cycle IDLE, mem_type_o = MEM_NOP, no rvalid pulse; a fresh request afterwards completes normally.
